// File: rtl/mac_array_ctrl.sv
// Purpose : job sequencer for a row x col weight-stationary MAC array (load weights, stream activations, drain, done).
// Latency : start to done = 2*row + col + num_act cycles, plus one cycle for every stalled LOAD_W/EXEC/DRAIN cycle.
// Backpressure: stall freezes state, phase counter and sram_addr, and masks w_load/act_en/sram_ren in the same cycle.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, num_act        job request (sampled in IDLE only) and activation vector count (latched with start)
//   stall                 output-FIFO back-pressure
//   busy, done            job in progress / one-cycle completion pulse
//   w_load, act_en, flush array strobes for the weight-load, activation and drain phases
//   sram_ren, sram_addr   operand SRAM read port
//   perf_cycles           busy-cycle count of the last completed job
// Optional feature: define MAC_CTRL_PERF_EN to build the perf_cycles counter; otherwise perf_cycles is tied to 0.

module mac_array_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int cnt_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [cnt_bw-1:0]  num_act,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic               w_load,
    output logic               act_en,
    output logic               flush,
    output logic               sram_ren,
    output logic [addr_bw-1:0] sram_addr,
    output logic [31:0]        perf_cycles
);

    // Phase counter must hold the longest phase length of the three counted phases.
    localparam int act_max   = (1 << cnt_bw) - 1;
    localparam int drain_len = row + col - 1;
    localparam int len_a     = (row > act_max) ? row : act_max;
    localparam int cnt_max   = (len_a > drain_len) ? len_a : drain_len;
    localparam int cnt_w     = $clog2(cnt_max + 1);

    localparam logic [cnt_w-1:0]   cnt_one    = cnt_w'(1);
    localparam logic [cnt_w-1:0]   load_last  = cnt_w'(row - 1);
    localparam logic [cnt_w-1:0]   drain_last = cnt_w'(drain_len - 1);
    localparam logic [addr_bw-1:0] addr_one   = addr_bw'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        EXEC   = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state;
    logic [cnt_w-1:0]   cnt;
    logic [cnt_bw-1:0]  na_q;
    logic               load_ph;
    logic               exec_ph;
    logic [cnt_w-1:0]   exec_last;

    // Only used in EXEC, which is never entered with na_q == 0.
    assign exec_last = cnt_w'(na_q) - cnt_one;

    // Phase flags and busy/done/flush are registered next to the state so the
    // outputs come straight from flops; only the stall gating is combinational.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            na_q      <= '0;
            sram_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            flush     <= 1'b0;
            load_ph   <= 1'b0;
            exec_ph   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD_W;
                        cnt       <= '0;
                        na_q      <= num_act;
                        sram_addr <= '0;
                        busy      <= 1'b1;
                        load_ph   <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (!stall) begin
                        sram_addr <= sram_addr + addr_one;
                        if (cnt == load_last) begin
                            cnt     <= '0;
                            load_ph <= 1'b0;
                            // An empty job skips the activation phase entirely.
                            if (na_q == '0) begin
                                state <= DRAIN;
                                flush <= 1'b1;
                            end else begin
                                state   <= EXEC;
                                exec_ph <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + cnt_one;
                        end
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        // Activation addresses continue on from the weight block and wrap silently.
                        sram_addr <= sram_addr + addr_one;
                        if (cnt == exec_last) begin
                            cnt     <= '0;
                            exec_ph <= 1'b0;
                            state   <= DRAIN;
                            flush   <= 1'b1;
                        end else begin
                            cnt <= cnt + cnt_one;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (cnt == drain_last) begin
                            cnt   <= '0;
                            flush <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + cnt_one;
                        end
                    end
                end
                DONE: begin
                    // Always exactly one cycle; a start seen here is dropped.
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    flush   <= 1'b0;
                    load_ph <= 1'b0;
                    exec_ph <= 1'b0;
                end
            endcase
        end
    end

    assign w_load   = load_ph & ~stall;
    assign act_en   = exec_ph & ~stall;
    assign sram_ren = w_load | act_en;

`ifdef MAC_CTRL_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_inc;

    // Saturating increment so a pathological stall storm cannot wrap the count.
    assign perf_inc = (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cnt <= '0;
        end else if (busy) begin
            perf_cnt <= perf_inc;
            // The done cycle itself is a busy cycle, so publish the incremented value.
            if (done) begin
                perf_cycles <= perf_inc;
            end
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencing controller for a `row`×`col` weight-stationary systolic array built from `mac` tiles (4-bit unsigned activation × 4-bit signed weight, 16-bit psum). On a `start` pulse it runs one job in four phases:

- loads `row` weight vectors from the local operand SRAM;
- streams `num_act` activation vectors into the array's left edge;
- waits for the skewed pipeline to drain;
- pulses `done`.

It sits between the top-level job issuer and the array/SRAM, and honours a `stall` back-pressure input from the output FIFO.

## Interface
Parameters:
- row, 8, array height (weight vectors per job)
- col, 8, array width
- cnt_bw, 8, width of `num_act`
- addr_bw, 11, SRAM address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock domain
- start  input  1  job request, sampled only in IDLE
- num_act  input  cnt_bw  activation vectors in the job; captured with `start`
- stall  input  1  freezes progress while high
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- w_load  output  1  array weight-load strobe
- act_en  output  1  activation-valid strobe to the array left edge
- flush  output  1  high during DRAIN
- sram_ren  output  1  SRAM read enable; equals w_load | act_en
- sram_addr  output  addr_bw  SRAM read address
- perf_cycles  output  32  busy-cycle count of the last completed job (see Configuration)

## Operation
- **States and transitions:**
  - IDLE → LOAD_W on `start`.
  - LOAD_W → EXEC after `row` non-stalled cycles, or LOAD_W → DRAIN if the captured `num_act` is 0.
  - EXEC → DRAIN after `num_act` non-stalled cycles.
  - DRAIN → DONE after `row+col-1` non-stalled cycles.
  - DONE → IDLE unconditionally.
- **Captures:** `num_act` is latched on `start`. Input changes during a job have no effect.
- **Single phase counter:**
  - Reset to 0 on each state entry.
  - Increments on each non-stalled cycle in LOAD_W, EXEC and DRAIN.
  - Width is sufficient for max(`row`, 2^cnt_bw−1, `row+col-1`).
- **Addressing:**
  - LOAD_W reads addresses 0…`row`−1.
  - EXEC reads `row`…`row+num_act`−1.
  - Address arithmetic is unsigned modulo 2^addr_bw and wraps silently.
- **Strobes:**
  - `w_load` and `act_en` are high only in their phase and only when `stall` = 0.
  - `flush` is high for all of DRAIN, stalled or not.
- **Stall:**
  - Freezes state, phase counter and `sram_addr`.
  - Has no effect in IDLE or DONE; DONE always lasts exactly one cycle.
- **`start` while not IDLE:** ignored. There is no queueing; a `start` that coincides with DONE is dropped.
- **Reset:** asserting `reset` mid-job aborts immediately to IDLE. No `done` pulse is produced.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `w_load`, `act_en`, `flush`, `sram_ren` = 0; `sram_addr` = 0; `perf_cycles` = 0.
- **Output timing:** all outputs are registered or decoded from registered state. There are no combinational paths from inputs, except that `stall` gates `w_load`, `act_en` and `sram_ren` in the same cycle.
- **Cycle timeline, with `start` high at edge T and no stall:**
  - `busy` rises after T.
  - `w_load` is high for cycles T+1…T+`row`.
  - `act_en` is high for T+`row`+1…T+`row`+`num_act`.
  - `flush` is high for the next `row+col-1` cycles.
  - `done` is high in cycle T+2·`row`+`col`+`num_act`.
  - `busy` falls together with `done`'s falling edge.
- **Effect of stall:** each stalled cycle in LOAD_W, EXEC or DRAIN extends the job by exactly one cycle.
- **Job latency:** minimum cycles from `start` to `done` = 2·`row`+`col`+`num_act`.
- **Back-to-back jobs:** the next `start` is accepted in the cycle after `done`.

## Configuration
- **Macro:** `MAC_CTRL_PERF_EN`.
- **Defined:**
  - A 32-bit counter clears on `start` acceptance and increments every cycle `busy` = 1, including stalled cycles.
  - The count is copied to `perf_cycles` when `done` pulses. It saturates at 2^32−1.
  - Reset clears it to 0.
- **Undefined:** `perf_cycles` is tied to 0 and no counter logic is generated.

## Test plan
Scenarios use row = 8, col = 8.

- **Basic job:** `num_act` = 4, no stall.
  - `w_load` high 8 cycles with `sram_addr` 0…7.
  - `act_en` high 4 cycles with `sram_addr` 8…11.
  - `flush` high 15 cycles.
  - `done` pulses 28 cycles after `start`.
  - `perf_cycles` = 28 (macro defined).
- **Stall injection:** `num_act` = 4; `stall` high for 3 cycles mid-EXEC and 2 cycles mid-DRAIN.
  - `act_en` is low while stalled and `sram_addr` holds.
  - `done` arrives at cycle 33.
- **Zero length:** `num_act` = 0.
  - No `act_en`.
  - LOAD_W goes directly to DRAIN; `done` at cycle 24.
- **Ignored starts:** `start` re-pulsed during EXEC and again in the DONE cycle.
  - Both are ignored and only one `done` occurs.
  - A `start` one cycle after `done` launches a new job.
- **Reset mid-job:** `reset` asserted during LOAD_W.
  - All outputs go to 0 asynchronously and `busy` = 0.
  - No `done`.
  - A subsequent `start` runs a full, correct job.
- **Maximum length:** `num_act` = 255 with `sram_addr` wrap (addr_bw = 8).
  - EXEC addresses run 8…255, then wrap to 0…6.
  - `done` at cycle 279.
